sm_cpz_intc: RTL and testbench

Parametrised vectored interrupt controller that sits between the external interrupt lines and the coprocessor-0 exception logic. It supports up to 32 sources, per-channel edge or level mode, masking, and fixed-priority arbitration. It produces a single request/acknowledge handshake and a computed handler vector for the CPU core. It tracks the in-service interrupt until exception return.

---
 rtl/sm_cpz_intc.sv | 180 ++++++++++++++++++
 tb/tb_sm_cpz_intc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_cpz_intc.sv
// Vectored interrupt controller feeding the coprocessor-0 exception logic.
// Per-channel edge/level capture, masking, fixed lowest-index-wins priority,
// a single req/ack handshake and in-service tracking until exception return.
// Optional macro SM_CONFIG_INTC_SYNC_EN inserts a 2-flop synchroniser on irq_in.
module sm_cpz_intc #(
  parameter int unsigned IRQ_NUM            = 8,
  parameter logic [31:0] VECTOR_BASE        = 32'h0000_0100,
  parameter int unsigned VECTOR_STRIDE_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_NUM-1:0] irq_in,
  output logic               irq_req,
  input  logic               irq_ack,
  input  logic               irq_eret,
  output logic [4:0]         irq_id,
  output logic [31:0]        irq_vector,
  input  logic [2:0]         reg_addr,
  input  logic [31:0]        reg_wd,
  input  logic               reg_we,
  output logic [31:0]        reg_rd
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } state_e;

  localparam logic [2:0] AddrCtrl   = 3'd0;
  localparam logic [2:0] AddrMask   = 3'd1;
  localparam logic [2:0] AddrMode   = 3'd2;
  localparam logic [2:0] AddrPend   = 3'd3;
  localparam logic [2:0] AddrStatus = 3'd4;

  state_e             state_q, state_d;
  logic [4:0]         id_q, id_d;
  logic               ge_q;
  logic [IRQ_NUM-1:0] mask_q, mode_q, pend_q, pend_d, prev_q;
  logic [IRQ_NUM-1:0] irq_s, elig, pend_set, pend_clr;
  logic [31:0]        elig_w, mode_w;
  logic [4:0]         win_id;
  logic               ack_edge_clr;
  logic               unused_wd;

  // Upper write-data bits are architecturally ignored.
  assign unused_wd = ^reg_wd;

`ifdef SM_CONFIG_INTC_SYNC_EN
  logic [IRQ_NUM-1:0] sync1_q, sync2_q;

  // Two-stage synchroniser for asynchronous interrupt lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign elig = pend_q & mask_q & {IRQ_NUM{ge_q}};

  // Zero-padded copies so a 5-bit id can index them for any IRQ_NUM.
  always_comb begin
    elig_w               = '0;
    mode_w               = '0;
    elig_w[IRQ_NUM-1:0]  = elig;
    mode_w[IRQ_NUM-1:0]  = mode_q;
  end

  // Fixed priority: scanning downwards leaves the lowest eligible index.
  always_comb begin
    win_id = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (elig[i]) win_id = i[4:0];
    end
  end

  // Handshake FSM next state; the chosen id is frozen outside IDLE.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    ack_edge_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|elig) begin
          state_d = StReq;
          id_d    = win_id;
        end
      end
      StReq: begin
        // Ack takes precedence over a simultaneous withdrawal.
        if (irq_ack) begin
          state_d      = StService;
          ack_edge_clr = mode_w[id_q];
        end else if (!elig_w[id_q]) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (irq_eret) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending next state: level channels follow the line, edge channels latch.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    pend_d   = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      pend_set[i] = irq_s[i] & ~prev_q[i];
      pend_clr[i] = (reg_we && (reg_addr == AddrPend) && reg_wd[i]) ||
                    (ack_edge_clr && (id_q == i[4:0]));
      if (mode_q[i]) begin
        // A new edge beats a clear in the same cycle.
        pend_d[i] = pend_set[i] | (pend_q[i] & ~pend_clr[i]);
      end else begin
        pend_d[i] = irq_s[i];
      end
    end
  end

  // State, pending and edge-history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      id_q    <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      prev_q  <= irq_s;
    end
  end

  // Software-writable configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ge_q   <= 1'b0;
      mask_q <= '0;
      mode_q <= '0;
    end else if (reg_we) begin
      case (reg_addr)
        AddrCtrl: ge_q   <= reg_wd[0];
        AddrMask: mask_q <= reg_wd[IRQ_NUM-1:0];
        AddrMode: mode_q <= reg_wd[IRQ_NUM-1:0];
        default:  ;
      endcase
    end
  end

  // Register read mux; unused addresses and bits read as zero.
  always_comb begin
    reg_rd = '0;
    case (reg_addr)
      AddrCtrl:   reg_rd[0]           = ge_q;
      AddrMask:   reg_rd[IRQ_NUM-1:0] = mask_q;
      AddrMode:   reg_rd[IRQ_NUM-1:0] = mode_q;
      AddrPend:   reg_rd[IRQ_NUM-1:0] = pend_q;
      AddrStatus: reg_rd              = {22'd0, state_q, 3'd0, id_q};
      default:    reg_rd              = '0;
    endcase
  end

  assign irq_req    = (state_q == StReq);
  assign irq_id     = id_q;
  assign irq_vector = VECTOR_BASE + ({27'd0, id_q} << VECTOR_STRIDE_LOG2);

endmodule

// File: tb/tb_sm_cpz_intc.sv
// Self-checking bench for sm_cpz_intc: directed vector table for the
// handshake corner cases, then random traffic against a behavioural model.
module tb_sm_cpz_intc;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_in;
  logic        irq_req;
  logic        irq_ack;
  logic        irq_eret;
  logic [4:0]  irq_id;
  logic [31:0] irq_vector;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wd;
  logic        reg_we;
  logic [31:0] reg_rd;

  int errors = 0;
  int checks = 0;

  sm_cpz_intc #(
    .IRQ_NUM(8),
    .VECTOR_BASE(32'h0000_0100),
    .VECTOR_STRIDE_LOG2(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .irq_in(irq_in),
    .irq_req(irq_req),
    .irq_ack(irq_ack),
    .irq_eret(irq_eret),
    .irq_id(irq_id),
    .irq_vector(irq_vector),
    .reg_addr(reg_addr),
    .reg_wd(reg_wd),
    .reg_we(reg_we),
    .reg_rd(reg_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        r;
    bit [7:0]  irq;
    bit        ack;
    bit        eret;
    bit        we;
    bit [2:0]  addr;
    bit [31:0] wd;
    bit        req;
    bit [4:0]  id;
    bit [31:0] rd;
  } vec_t;

  vec_t tv[$];

  // Behavioural model state: state 0 idle, 1 requesting, 2 in service.
  int       m_st;
  int       m_id;
  bit       m_ge;
  bit [7:0] m_mask, m_mode, m_pend, m_prev, m_s1, m_s2;

  task automatic add(input bit r, input bit [7:0] irq, input bit ack, input bit eret,
                     input bit we, input bit [2:0] addr, input bit [31:0] wd,
                     input bit req, input bit [4:0] id, input bit [31:0] rd);
    vec_t v;
    v.r = r; v.irq = irq; v.ack = ack; v.eret = eret; v.we = we;
    v.addr = addr; v.wd = wd; v.req = req; v.id = id; v.rd = rd;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_id = 0; m_ge = 0;
    m_mask = '0; m_mode = '0; m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
  endtask

  // One clock of the controller, computed from the rules on the current inputs.
  task automatic model_step();
    bit [7:0] eff, elig, np;
    int       nst, nid, ack_ch;
    if (rst) begin
      model_reset();
      return;
    end
`ifdef SM_CONFIG_INTC_SYNC_EN
    eff = m_s2;
`else
    eff = irq_in;
`endif
    elig   = m_ge ? (m_pend & m_mask) : 8'h00;
    nst    = m_st;
    nid    = m_id;
    ack_ch = -1;
    if (m_st == 0) begin
      for (int i = 7; i >= 0; i--) if (elig[i]) begin nst = 1; nid = i; end
    end else if (m_st == 1) begin
      if (irq_ack) begin
        nst = 2;
        if (m_mode[m_id]) ack_ch = m_id;
      end else if (!elig[m_id]) begin
        nst = 0;
      end
    end else if (irq_eret) begin
      nst = 0;
    end
    for (int i = 0; i < 8; i++) begin
      if (m_mode[i]) begin
        bit rise, clr;
        rise  = eff[i] && !m_prev[i];
        clr   = (reg_we && reg_addr == 3'd3 && reg_wd[i]) || (ack_ch == i);
        np[i] = rise || (m_pend[i] && !clr);
      end else begin
        np[i] = eff[i];
      end
    end
    if (reg_we) begin
      if (reg_addr == 3'd0) m_ge   = reg_wd[0];
      if (reg_addr == 3'd1) m_mask = reg_wd[7:0];
      if (reg_addr == 3'd2) m_mode = reg_wd[7:0];
    end
    m_pend = np;
    m_prev = eff;
    m_s2   = m_s1;
    m_s1   = irq_in;
    m_st   = nst;
    m_id   = nid;
  endtask

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    case (a)
      3'd0: return {31'd0, m_ge};
      3'd1: return {24'd0, m_mask};
      3'd2: return {24'd0, m_mode};
      3'd3: return {24'd0, m_pend};
      3'd4: return (m_st * 256) + m_id;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; irq_ack = 0; irq_eret = 0;
    reg_we = 0; reg_addr = 3'd4; reg_wd = '0;

`ifndef SM_CONFIG_INTC_SYNC_EN
    //   r irq    ack eret we addr wd            req id  rd
    add(1, 8'h00, 0, 0, 0, 3'd4, 32'h0,        0, 0, 32'h000);
    add(0, 8'h00, 0, 0, 1, 3'd0, 32'h1,        0, 0, 32'h001);
    add(0, 8'h00, 0, 0, 1, 3'd1, 32'hFF,       0, 0, 32'h0FF);
    add(0, 8'h00, 0, 0, 1, 3'd2, 32'h0,        0, 0, 32'h000);
    add(0, 8'h08, 0, 0, 0, 3'd3, 32'h0,        0, 0, 32'h008);
    add(0, 8'h08, 0, 0, 0, 3'd4, 32'h0,        1, 3, 32'h103);
    add(0, 8'h0A, 0, 0, 0, 3'd4, 32'h0,        1, 3, 32'h103);
    add(0, 8'h0A, 1, 0, 0, 3'd4, 32'h0,        0, 3, 32'h203);
    add(0, 8'h0A, 0, 1, 0, 3'd4, 32'h0,        0, 3, 32'h003);
    add(0, 8'h0A, 0, 0, 0, 3'd4, 32'h0,        1, 1, 32'h101);
    add(0, 8'h0A, 1, 0, 0, 3'd4, 32'h0,        0, 1, 32'h201);
    add(0, 8'h00, 0, 1, 0, 3'd4, 32'h0,        0, 1, 32'h001);
    add(0, 8'h00, 0, 0, 0, 3'd4, 32'h0,        0, 1, 32'h001);
    // edge channel 5
    add(0, 8'h00, 0, 0, 1, 3'd2, 32'h20,       0, 1, 32'h020);
    add(0, 8'h20, 0, 0, 0, 3'd3, 32'h0,        0, 1, 32'h020);
    add(0, 8'h00, 0, 0, 0, 3'd4, 32'h0,        1, 5, 32'h105);
    add(0, 8'h00, 1, 0, 0, 3'd3, 32'h0,        0, 5, 32'h000);
    add(0, 8'h20, 0, 0, 0, 3'd3, 32'h0,        0, 5, 32'h020);
    add(0, 8'h00, 0, 0, 0, 3'd4, 32'h0,        0, 5, 32'h205);
    add(0, 8'h00, 0, 1, 0, 3'd4, 32'h0,        0, 5, 32'h005);
    add(0, 8'h00, 0, 0, 0, 3'd4, 32'h0,        1, 5, 32'h105);
    add(0, 8'h00, 1, 0, 0, 3'd3, 32'h0,        0, 5, 32'h000);
    add(0, 8'h00, 0, 1, 0, 3'd4, 32'h0,        0, 5, 32'h005);
    // level channel 2 withdrawal, then ack racing withdrawal
    add(0, 8'h04, 0, 0, 0, 3'd4, 32'h0,        0, 5, 32'h005);
    add(0, 8'h04, 0, 0, 0, 3'd4, 32'h0,        1, 2, 32'h102);
    add(0, 8'h00, 0, 0, 0, 3'd4, 32'h0,        1, 2, 32'h102);
    add(0, 8'h00, 0, 0, 0, 3'd4, 32'h0,        0, 2, 32'h002);
    add(0, 8'h04, 0, 0, 0, 3'd4, 32'h0,        0, 2, 32'h002);
    add(0, 8'h04, 0, 0, 0, 3'd4, 32'h0,        1, 2, 32'h102);
    add(0, 8'h00, 0, 0, 0, 3'd4, 32'h0,        1, 2, 32'h102);
    add(0, 8'h00, 1, 0, 0, 3'd4, 32'h0,        0, 2, 32'h202);
    add(0, 8'h00, 0, 1, 0, 3'd4, 32'h0,        0, 2, 32'h002);
    // edge channel 0: W1C racing a new edge
    add(0, 8'h00, 0, 0, 1, 3'd2, 32'h21,       0, 2, 32'h021);
    add(0, 8'h01, 0, 0, 0, 3'd3, 32'h0,        0, 2, 32'h001);
    add(0, 8'h00, 0, 0, 0, 3'd3, 32'h0,        1, 0, 32'h001);
    add(0, 8'h01, 0, 0, 1, 3'd3, 32'h1,        1, 0, 32'h001);
    add(0, 8'h00, 0, 0, 1, 3'd3, 32'h1,        1, 0, 32'h000);
    add(0, 8'h00, 0, 0, 0, 3'd4, 32'h0,        0, 0, 32'h000);
    // reset while in service
    add(0, 8'h01, 0, 0, 0, 3'd3, 32'h0,        0, 0, 32'h001);
    add(0, 8'h00, 0, 0, 0, 3'd4, 32'h0,        1, 0, 32'h100);
    add(0, 8'h00, 1, 0, 0, 3'd4, 32'h0,        0, 0, 32'h200);
    add(1, 8'h00, 0, 0, 0, 3'd1, 32'h0,        0, 0, 32'h000);
    add(0, 8'h00, 0, 0, 0, 3'd4, 32'h0,        0, 0, 32'h000);
    add(0, 8'h00, 0, 0, 1, 3'd5, 32'hFFFFFFFF, 0, 0, 32'h000);
    add(0, 8'h00, 1, 1, 0, 3'd4, 32'h0,        0, 0, 32'h000);
    add(0, 8'h00, 0, 0, 0, 3'd0, 32'h0,        0, 0, 32'h000);

    foreach (tv[k]) begin
      rst = tv[k].r; irq_in = tv[k].irq; irq_ack = tv[k].ack; irq_eret = tv[k].eret;
      reg_we = tv[k].we; reg_addr = tv[k].addr; reg_wd = tv[k].wd;
      tick();
      chk($sformatf("vec%0d.req", k), {31'd0, irq_req}, {31'd0, tv[k].req});
      chk($sformatf("vec%0d.id", k), {27'd0, irq_id}, {27'd0, tv[k].id});
      chk($sformatf("vec%0d.vector", k), irq_vector, 32'h100 + 32'(tv[k].id) * 32);
      chk($sformatf("vec%0d.rd", k), reg_rd, tv[k].rd);
    end
`endif

    // Random traffic against the model, starting from a reset.
    rst = 1'b1; irq_in = '0; irq_ack = 0; irq_eret = 0; reg_we = 0;
    tick();
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 399) == 0);
      irq_in   = irq_in ^ 8'($urandom & $urandom & $urandom);
      irq_ack  = ($urandom_range(0, 3) == 0);
      irq_eret = ($urandom_range(0, 3) == 0);
      reg_we   = ($urandom_range(0, 9) == 0);
      reg_addr = 3'($urandom_range(0, 7));
      reg_wd   = $urandom;
      if (reg_addr == 3'd0 && $urandom_range(0, 3) != 0) reg_wd[0] = 1'b1;
      tick();
      chk("rand.req", {31'd0, irq_req}, {31'd0, m_st == 1});
      chk("rand.id", {27'd0, irq_id}, 32'(m_id));
      chk("rand.vector", irq_vector, 32'h100 + 32'(m_id) * 32);
      chk("rand.rd", reg_rd, model_rd(reg_addr));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
